// File: rtl/ddr3_arbiter.sv
// ddr3_arbiter: two-port round-robin arbiter feeding a DDR3 controller app interface,
// one transaction in flight, all controller- and port-facing outputs registered.
module ddr3_arbiter #(
    parameter int ADDR_W = 28,
    parameter int DATA_W = 128,
    parameter int MASK_W = 16
) (
    input  logic              ui_clk,
    input  logic              sys_rst,
    input  logic              init_calib_complete,
    input  logic              p0_req,
    input  logic              p0_we,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    input  logic [MASK_W-1:0] p0_wmask,
    output logic              p0_ack,
    output logic              p0_rvalid,
    output logic [DATA_W-1:0] p0_rdata,
    input  logic              p1_req,
    input  logic              p1_we,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    input  logic [MASK_W-1:0] p1_wmask,
    output logic              p1_ack,
    output logic              p1_rvalid,
    output logic [DATA_W-1:0] p1_rdata,
    output logic [ADDR_W-1:0] app_addr,
    output logic [2:0]        app_cmd,
    output logic              app_en,
    output logic [DATA_W-1:0] app_wdf_data,
    output logic [MASK_W-1:0] app_wdf_mask,
    output logic              app_wdf_wren,
    output logic              app_wdf_end,
    input  logic              app_rdy,
    input  logic              app_wdf_rdy,
    input  logic [DATA_W-1:0] app_rd_data,
    input  logic              app_rd_data_valid,
    output logic              busy
);
    typedef enum logic [1:0] {IDLE, WRITE, RD_CMD, RD_WAIT} state_t;
    state_t            state_q, state_d;
    logic              port_q, port_d, last_q, last_d;
    logic              cacc_q, cacc_d, dacc_q, dacc_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [2:0]        cmd_q, cmd_d;
    logic              en_q, en_d, wren_q, wren_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [MASK_W-1:0] wmask_q, wmask_d;
    logic              ack0_q, ack0_d, ack1_q, ack1_d, rv0_q, rv0_d, rv1_q, rv1_d;
    logic [DATA_W-1:0] rd0_q, rd0_d, rd1_q, rd1_d;
    logic              sel, sel_we, cmd_ok, dat_ok;
    // p1 wins only when p0 is idle or p0 was the last one served
    assign sel    = p1_req & (~p0_req | ~last_q);
    assign sel_we = sel ? p1_we : p0_we;
    assign cmd_ok = cacc_q | (en_q & app_rdy);
    assign dat_ok = dacc_q | (wren_q & app_wdf_rdy);
    always_comb begin
        state_d = state_q;
        port_d  = port_q;
        last_d  = last_q;
        cacc_d  = cacc_q;
        dacc_d  = dacc_q;
        addr_d  = addr_q;
        cmd_d   = cmd_q;
        en_d    = en_q;
        wren_d  = wren_q;
        wdata_d = wdata_q;
        wmask_d = wmask_q;
        rd0_d   = rd0_q;
        rd1_d   = rd1_q;
        ack0_d  = 1'b0;
        ack1_d  = 1'b0;
        rv0_d   = 1'b0;
        rv1_d   = 1'b0;
        case (state_q)
            IDLE: if (init_calib_complete & (p0_req | p1_req)) begin
                port_d  = sel;
                last_d  = sel;
                addr_d  = sel ? p1_addr : p0_addr;
                wdata_d = sel ? p1_wdata : p0_wdata;
                wmask_d = sel ? p1_wmask : p0_wmask;
                cmd_d   = sel_we ? 3'b000 : 3'b001;
                en_d    = 1'b1;
                wren_d  = sel_we;
                cacc_d  = 1'b0;
                dacc_d  = 1'b0;
                state_d = sel_we ? WRITE : RD_CMD;
            end
            WRITE: begin
                en_d   = en_q & ~app_rdy;
                wren_d = wren_q & ~app_wdf_rdy;
                cacc_d = cmd_ok;
                dacc_d = dat_ok;
                if (cmd_ok & dat_ok) begin
                    ack0_d  = ~port_q;
                    ack1_d  = port_q;
                    cacc_d  = 1'b0;
                    dacc_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            RD_CMD: if (app_rdy) begin
                en_d    = 1'b0;
                state_d = RD_WAIT;
            end
            RD_WAIT: if (app_rd_data_valid) begin
                rd0_d   = port_q ? rd0_q : app_rd_data;
                rd1_d   = port_q ? app_rd_data : rd1_q;
                ack0_d  = ~port_q;
                ack1_d  = port_q;
                rv0_d   = ~port_q;
                rv1_d   = port_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge ui_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            state_q <= IDLE;
            port_q  <= 1'b0;
            last_q  <= 1'b1;
            cacc_q  <= 1'b0;
            dacc_q  <= 1'b0;
            addr_q  <= '0;
            cmd_q   <= '0;
            en_q    <= 1'b0;
            wren_q  <= 1'b0;
            wdata_q <= '0;
            wmask_q <= '0;
            ack0_q  <= 1'b0;
            ack1_q  <= 1'b0;
            rv0_q   <= 1'b0;
            rv1_q   <= 1'b0;
            rd0_q   <= '0;
            rd1_q   <= '0;
        end else begin
            state_q <= state_d;
            port_q  <= port_d;
            last_q  <= last_d;
            cacc_q  <= cacc_d;
            dacc_q  <= dacc_d;
            addr_q  <= addr_d;
            cmd_q   <= cmd_d;
            en_q    <= en_d;
            wren_q  <= wren_d;
            wdata_q <= wdata_d;
            wmask_q <= wmask_d;
            ack0_q  <= ack0_d;
            ack1_q  <= ack1_d;
            rv0_q   <= rv0_d;
            rv1_q   <= rv1_d;
            rd0_q   <= rd0_d;
            rd1_q   <= rd1_d;
        end
    end
    assign app_addr     = addr_q;
    assign app_cmd      = cmd_q;
    assign app_en       = en_q;
    assign app_wdf_data = wdata_q;
    assign app_wdf_mask = wmask_q;
    assign app_wdf_wren = wren_q;
    assign app_wdf_end  = wren_q;
    assign p0_ack       = ack0_q;
    assign p1_ack       = ack1_q;
    assign p0_rvalid    = rv0_q;
    assign p1_rvalid    = rv1_q;
    assign p0_rdata     = rd0_q;
    assign p1_rdata     = rd1_q;
    assign busy         = state_q != IDLE;
endmodule

// File: doc/ddr3_arbiter.md
DDR3_ARBITER -- requirements
Module: ddr3_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 28, app_addr width.
REQ-002 SHALL have parameter DATA_W, default 128, app data width.
REQ-003 SHALL have parameter MASK_W, default 16, DATA_W/8 write-mask width.
REQ-004 SHALL have port ui_clk  in  1  sole clock, the controller user clock.
REQ-005 SHALL have port sys_rst  in  1  asynchronous, active-low reset.
REQ-006 SHALL have port init_calib_complete  in  1  controller calibration done.
REQ-007 SHALL have ports pN_req  in  1  request, for N=0,1, held until pN_ack.
REQ-008 SHALL have ports pN_we  in  1  1=write, 0=read.
REQ-009 SHALL have ports pN_addr  in  ADDR_W  request address.
REQ-010 SHALL have ports pN_wdata  in  DATA_W  write data.
REQ-011 SHALL have ports pN_wmask  in  MASK_W  write byte mask, 1=masked.
REQ-012 SHALL have ports pN_ack  out  1  one-cycle completion pulse.
REQ-013 SHALL have ports pN_rvalid  out  1  one-cycle read-data pulse.
REQ-014 SHALL have ports pN_rdata  out  DATA_W  read data, valid with pN_rvalid.
REQ-015 SHALL have ports app_addr out ADDR_W, app_cmd out 3, app_en out 1, driving the controller command port.
REQ-016 SHALL have ports app_wdf_data out DATA_W, app_wdf_mask out MASK_W, app_wdf_wren out 1, app_wdf_end out 1, driving the write-data port.
REQ-017 SHALL have ports app_rdy in 1, app_wdf_rdy in 1, app_rd_data in DATA_W, app_rd_data_valid in 1, from the controller.
REQ-018 SHALL have port busy  out  1  high whenever the state is not IDLE.

Function
REQ-019 SHALL implement states IDLE, WRITE, RD_CMD, RD_WAIT, with one transaction outstanding at a time.
REQ-020 In IDLE, with init_calib_complete=0, SHALL grant nothing; requests wait.
REQ-021 In IDLE, with calibration done, SHALL grant a single requester: when only one requests, grant it; when both request, grant the one not granted last. last_grant resets to 1, so p0 wins the first tie.
REQ-022 On grant, SHALL latch addr, we, wdata and wmask, and SHALL record the granted port.
REQ-023 On grant, SHALL go to WRITE if we=1, otherwise to RD_CMD; app_en SHALL assert on the next cycle.
REQ-024 All app_* outputs and pN_* outputs SHALL be registered.
REQ-025 In WRITE, SHALL drive app_cmd=3'b000 with app_en=1 until a cycle where app_en&app_rdy; app_en SHALL be 0 from the following cycle.
REQ-026 In WRITE, SHALL hold app_wdf_wren=app_wdf_end=1 with latched data/mask until a cycle where app_wdf_wren&app_wdf_rdy.
REQ-027 Command and data acceptance SHALL be tracked independently; they may complete in either order or in the same cycle.
REQ-028 When both command and data are accepted, SHALL pulse the granted port's pN_ack for one cycle and return to IDLE.
REQ-029 In RD_CMD, SHALL drive app_cmd=3'b001 with app_en=1 until app_rdy is sampled high, then enter RD_WAIT with app_en=0.
REQ-030 In RD_WAIT, on app_rd_data_valid=1, SHALL register app_rd_data into the granted port's pN_rdata, pulse pN_rvalid and pN_ack in the same cycle, and return to IDLE.
REQ-031 SHALL ignore app_rd_data_valid outside RD_WAIT.
REQ-032 Minimum write latency: req sampled in cycle T (IDLE) with app_rdy=app_wdf_rdy=1 -> pN_ack high in cycle T+2.
REQ-033 A requester dropping pN_req mid-transaction SHALL NOT abort it; ack is still issued.
REQ-034 init_calib_complete falling mid-transaction SHALL NOT abort it; it only blocks new grants.
REQ-035 The port re-sampled in IDLE, the cycle after its own ack, SHALL be treated as a new request.
REQ-036 pN_rdata SHALL hold its value until the next read completes for that port.

Reset
REQ-037 On sys_rst=0, SHALL asynchronously enter IDLE, clear the acceptance flags and set last_grant=1.
REQ-038 On sys_rst=0, every output SHALL be 0: app_en, app_cmd, app_addr, app_wdf_*, pN_ack, pN_rvalid, pN_rdata and busy.
REQ-039 Reset asserted mid-transaction SHALL abandon the transaction with no ack.

Verification
REQ-040 Bench SHALL drive init_calib_complete=0 with p0_req=1 for 20 cycles -> app_en stays 0 and busy=0; raise calibration -> app_en=1 on the second following cycle.
REQ-041 Bench SHALL issue a p0 write to addr 0x100, data 0xA5..A5, mask 0, with app_rdy=1 and app_wdf_rdy=0 for 3 cycles -> app_en drops after 1 cycle, wren holds 4 cycles, and one p0_ack follows the data accept.
REQ-042 Bench SHALL issue a p1 read to addr 0x200 with app_rd_data_valid after 10 cycles carrying 0x1234 -> p1_rdata=0x1234, p1_rvalid=p1_ack=1 for exactly one cycle, and p0_* stay 0.
REQ-043 Bench SHALL hold p0_req and p1_req continuously for 6 transactions -> grants alternate p0,p1,p0,p1,p0,p1.
REQ-044 Bench SHALL assert sys_rst=0 during RD_WAIT, then release it and inject app_rd_data_valid -> no ack or rvalid, and the state stays IDLE.
